// File: rtl/genetico_pkg.sv
// Shared definitions for the chromosome interface.
//
// Holds the default geometry of the evolvable circuit, helper functions that
// derive the chromosome width and payload length from that geometry, the
// frame header byte, and the state encoding of the serial loader.
package genetico_pkg;

    // Default circuit geometry.
    localparam int unsigned DEF_ROW       = 1;
    localparam int unsigned DEF_COL       = 3;
    localparam int unsigned DEF_OUT       = 2;
    localparam int unsigned DEF_BITS_ELEM = 1;

    // First byte of every loader frame.
    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        COMMIT
    } loader_state_t;

    // Bits used by the logic-element descriptor matrix (16 per element).
    function automatic int unsigned calc_bits_mat(input int unsigned row,
                                                  input int unsigned col);
        return row * col * 16;
    endfunction

    // Full chromosome width: descriptor matrix plus output selectors.
    function automatic int unsigned calc_chrom_w(input int unsigned row,
                                                 input int unsigned col,
                                                 input int unsigned out,
                                                 input int unsigned bits_elem);
        return calc_bits_mat(row, col) + bits_elem * out;
    endfunction

    // Payload bytes needed to carry a chromosome of the given width.
    function automatic int unsigned calc_nbytes(input int unsigned chrom_w);
        return (chrom_w + 7) / 8;
    endfunction

endpackage

// File: rtl/chrom_serial_loader.sv
// Serial writer side of the chromosome interface.
//
// Accepts a framed byte stream (header 0xA5, NBYTES payload bytes LSB-first,
// XOR checksum byte) over a valid/ready handshake, assembles the payload in a
// shadow register and, if the checksum matches, commits it atomically to the
// parallel chromosome bus.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     byte present on in_data
//   in_data      stream byte
//   in_ready     loader accepts the byte this cycle
//   abort        synchronous frame abort (priority over in_valid)
//   chrom_out    active chromosome; bit 0 is the LSB of descriptor[0][0]
//   chrom_valid  high once any frame has committed
//   load_done    one-cycle pulse on a successful commit
//   load_err     one-cycle pulse on a checksum mismatch
//   busy         high while a frame is in progress
module chrom_serial_loader
    import genetico_pkg::*;
#(
    parameter int unsigned ROW       = DEF_ROW,
    parameter int unsigned COL       = DEF_COL,
    parameter int unsigned OUT       = DEF_OUT,
    parameter int unsigned BITS_ELEM = DEF_BITS_ELEM,
    parameter logic [calc_chrom_w(ROW, COL, OUT, BITS_ELEM)-1:0] RESET_CHROM = '0
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               in_valid,
    input  logic [7:0]                                         in_data,
    output logic                                               in_ready,
    input  logic                                               abort,
    output logic [calc_chrom_w(ROW, COL, OUT, BITS_ELEM)-1:0]  chrom_out,
    output logic                                               chrom_valid,
    output logic                                               load_done,
    output logic                                               load_err,
    output logic                                               busy
);

    localparam int unsigned CHROM_W = calc_chrom_w(ROW, COL, OUT, BITS_ELEM);
    localparam int unsigned NBYTES  = calc_nbytes(CHROM_W);
    localparam int unsigned CNT_W   = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    loader_state_t        state_q,       state_d;
    logic [CHROM_W-1:0]   shadow_q,      shadow_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic [7:0]           xor_q,         xor_d;
    logic [CHROM_W-1:0]   chrom_q,       chrom_d;
    logic                 chrom_valid_q, chrom_valid_d;
    logic                 load_done_q,   load_done_d;
    logic                 load_err_q,    load_err_d;

    logic                 accept;

    assign in_ready    = (state_q != COMMIT) && !abort;
    assign accept      = in_valid && in_ready;
    assign busy        = (state_q != IDLE);
    assign chrom_out   = chrom_q;
    assign chrom_valid = chrom_valid_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            cnt_q         <= '0;
            xor_q         <= '0;
            chrom_q       <= RESET_CHROM;
            chrom_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            cnt_q         <= cnt_d;
            xor_q         <= xor_d;
            chrom_q       <= chrom_d;
            chrom_valid_q <= chrom_valid_d;
            load_done_q   <= load_done_d;
            load_err_q    <= load_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        cnt_d         = cnt_q;
        xor_d         = xor_q;
        chrom_d       = chrom_q;
        chrom_valid_d = chrom_valid_q;
        load_done_d   = 1'b0;
        load_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Anything other than a header is dropped without comment.
                if (accept && (in_data == FRAME_HDR)) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    xor_d   = '0;
                end
            end

            PAYLOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    // Bit-wise write so shadow only holds CHROM_W bits; the
                    // padding bits of the last byte never land anywhere but
                    // still feed the checksum below.
                    for (int unsigned i = 0; i < CHROM_W; i++) begin
                        if (32'(cnt_q) == (i / 8)) begin
                            shadow_d[i] = in_data[3'(i % 8)];
                        end
                    end
                    xor_d = xor_q ^ in_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (in_data == xor_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d    = IDLE;
                        load_err_d = 1'b1;
                    end
                end
            end

            COMMIT: begin
                // in_ready is low here, so abort and in_valid cannot interfere.
                chrom_d       = shadow_q;
                chrom_valid_d = 1'b1;
                load_done_d   = 1'b1;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/chrom_serial_loader.md
Name: chrom_serial_loader

Overview:
- Serial writer side of the chromosome interface.
- Receives a framed byte stream over a valid/ready handshake and assembles the bytes into a shadow chromosome register.
- Checks an XOR checksum, then atomically commits the result to the parallel chromosome bus that feeds the descriptor/output-selector slicing in front of newGenetico.
- Replaces the hard-coded chromosome constant, so new individuals can be loaded at run time.

Parameters:
- ROW, 1, rows of logic elements.
- COL, 3, columns of logic elements.
- OUT, 2, number of circuit outputs.
- BITS_ELEM, 1, bits per output selector.
- RESET_CHROM, 0, chromosome value loaded on reset; width CHROM_W.
- Derived, not overridable:
  - BITS_MAT = ROW*COL*16
  - CHROM_W = BITS_MAT + BITS_ELEM*OUT (50 with the defaults)
  - NBYTES = ceil(CHROM_W/8) (7 with the defaults)

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- abort  in  1  synchronous frame abort.
- chrom_out  out  CHROM_W  active chromosome; bit 0 is the LSB of descriptor[0][0].
- chrom_valid  out  1  high once any frame has committed.
- load_done  out  1  one-cycle pulse on a successful commit.
- load_err  out  1  one-cycle pulse on a checksum mismatch.
- busy  out  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Reset values (async, rst_n low):
  - chrom_out = RESET_CHROM; chrom_valid = 0; load_done = 0; load_err = 0.
  - State = IDLE; shadow register = 0; byte counter = 0; running XOR = 0.
- Handshake:
  - A byte transfers on a rising edge where in_valid && in_ready.
  - in_ready = 1 in IDLE, PAYLOAD and CHECK.
  - in_ready = 0 in COMMIT, and in any cycle where abort = 1.
- Frame format: header 0xA5, then NBYTES payload bytes LSB-first (byte k fills shadow[8k+7:8k]), then a checksum byte equal to the XOR of all payload bytes.
- Padding: bits of the last payload byte above CHROM_W-1 are discarded, but they are still included in the checksum.
- States:
  - IDLE: accepted 0xA5 → PAYLOAD, with counter = 0 and XOR = 0. Any other accepted byte is silently dropped.
  - PAYLOAD: each accepted byte is written into the shadow at the counter index and folded into XOR; the counter increments. Accepting byte NBYTES-1 → CHECK.
  - CHECK: the accepted byte is compared with XOR. Equal → COMMIT. Unequal → IDLE, with load_err = 1 in the next cycle; chrom_out is unchanged.
  - COMMIT: lasts exactly one cycle. On its closing edge chrom_out <= shadow[CHROM_W-1:0], chrom_valid <= 1, load_done = 1 for the following cycle, and state → IDLE.
- Latency: with the checksum accepted on edge E, chrom_out and load_done change on edge E+1; load_done falls on edge E+2.
- No partial update: chrom_out never reflects a partially received frame.
- abort:
  - In PAYLOAD or CHECK: state → IDLE on the next edge; shadow contents are don't-care; no pulse is generated.
  - In COMMIT: ignored, and the commit completes.
  - In IDLE: no effect.
  - abort has priority over a simultaneous in_valid.
- A header byte (0xA5) received inside PAYLOAD is treated as data; there is no resynchronisation except by abort or a checksum error.
- Asserting rst_n low mid-frame returns all outputs to their reset values immediately, including chrom_out = RESET_CHROM.
- Counter width = $clog2(NBYTES)+1; the counter does not wrap within a frame.
- Back-to-back frames are allowed: a header may be accepted in the first IDLE cycle after COMMIT.

Decomposition:
- Package genetico_pkg holds:
  - the ROW/COL/OUT/BITS_ELEM defaults;
  - localparam functions for BITS_MAT, CHROM_W and NBYTES;
  - FRAME_HDR = 8'hA5;
  - typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} loader_state_t.
- Single module; no sub-module is warranted.
- The slicing top instantiates chrom_serial_loader and drives its cromossomo bus from chrom_out.

Test Plan:
- Reset release with no traffic → chrom_out = RESET_CHROM, chrom_valid = 0, busy = 0, in_ready = 1.
- Good frame (defaults): A5, 01, 02, 03, 04, 05, 06, 07, checksum 00 → one cycle after the checksum, chrom_out = {2'b11, 48'h060504030201}, chrom_valid = 1, load_done high for exactly 1 cycle, in_ready low only in the COMMIT cycle.
- Bad checksum: same payload with checksum 0x5A → load_err pulses once, chrom_out keeps its prior value, state returns to IDLE.
- Garbage then frame: 0x00, 0xFF, then a valid frame → the first two bytes are dropped and the commit is correct.
- Abort after the 3rd payload byte, then a full frame with payload FF×7 and checksum FF → no pulse on abort; the second frame commits chrom_out = 50'h3_FFFF_FFFF_FFFF.
- rst_n pulsed low during CHECK after a prior commit → chrom_out = RESET_CHROM and chrom_valid = 0 asynchronously; the next valid frame loads normally.
